// File: rtl/core_lsu.sv
// core_lsu: load/store unit between the core's memory-access stage and the
// data memory port. Turns one load/store request into a word-aligned,
// byte-enabled memory access with a req/ack handshake. Load data comes back
// lane-shifted and sign/zero-extended. Misaligned accesses and memory
// timeouts complete with ERR instead of being issued or waited on forever.
//
// Ports:
//   CLK, RST_N        clock, synchronous active-low reset
//   REQ, ADDR, WDATA  core request, byte address, store source
//   OP_*              one-hot operation select (LB/LH/LW/LBU/LHU/SB/SH/SW)
//   BUSY, DONE, ERR   status, one-cycle completion pulse, error flag
//   RDATA             extended load result, held until the next accept
//   D_REQ .. D_WDATA  registered memory request side
//   D_ACK, D_RDATA    memory acknowledge and read word
module core_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  input  logic        OP_LB,
  input  logic        OP_LH,
  input  logic        OP_LW,
  input  logic        OP_LBU,
  input  logic        OP_LHU,
  input  logic        OP_SB,
  input  logic        OP_SH,
  input  logic        OP_SW,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic        D_REQ,
  output logic [31:0] D_ADDR,
  output logic        D_WE,
  output logic [3:0]  D_BE,
  output logic [31:0] D_WDATA,
  input  logic        D_ACK,
  input  logic [31:0] D_RDATA
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [2:0] {
    OPC_LB, OPC_LH, OPC_LW, OPC_LBU, OPC_LHU, OPC_SB, OPC_SH, OPC_SW
  } op_t;

  state_t           state;
  op_t              op_q;
  logic [1:0]       lo_q;
  logic [CNT_W-1:0] cnt;

  op_t         req_op;
  logic        req_any;
  logic        req_store;
  logic        req_mis;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic [31:0] shifted;
  logic [31:0] load_c;

  // Decode the incoming op: priority pick, alignment, byte enables, lanes.
  always_comb begin
    req_op  = OPC_LB;
    req_any = 1'b1;
    if      (OP_LB)  req_op = OPC_LB;
    else if (OP_LH)  req_op = OPC_LH;
    else if (OP_LW)  req_op = OPC_LW;
    else if (OP_LBU) req_op = OPC_LBU;
    else if (OP_LHU) req_op = OPC_LHU;
    else if (OP_SB)  req_op = OPC_SB;
    else if (OP_SH)  req_op = OPC_SH;
    else if (OP_SW)  req_op = OPC_SW;
    else             req_any = 1'b0;

    req_store = 1'b0;
    req_mis   = 1'b0;
    req_be    = 4'b1111;
    req_wd    = WDATA;
    case (req_op)
      OPC_LB, OPC_LBU: req_be = 4'b0001 << ADDR[1:0];
      OPC_SB: begin
        req_store = 1'b1;
        req_be    = 4'b0001 << ADDR[1:0];
        req_wd    = {4{WDATA[7:0]}};
      end
      OPC_LH, OPC_LHU: begin
        req_mis = ADDR[0];
        req_be  = 4'b0011 << {ADDR[1], 1'b0};
      end
      OPC_SH: begin
        req_store = 1'b1;
        req_mis   = ADDR[0];
        req_be    = 4'b0011 << {ADDR[1], 1'b0};
        req_wd    = {2{WDATA[15:0]}};
      end
      OPC_LW: req_mis = |ADDR[1:0];
      OPC_SW: begin
        req_store = 1'b1;
        req_mis   = |ADDR[1:0];
      end
      default: req_be = 4'b1111;
    endcase
  end

  // Lane-shift and extend the returned word for the latched load type.
  always_comb begin
    shifted = D_RDATA >> {lo_q, 3'b000};
    load_c  = 32'h0;
    case (op_q)
      OPC_LB:  load_c = {{24{shifted[7]}}, shifted[7:0]};
      OPC_LBU: load_c = {24'h0, shifted[7:0]};
      OPC_LH:  load_c = {{16{shifted[15]}}, shifted[15:0]};
      OPC_LHU: load_c = {16'h0, shifted[15:0]};
      OPC_LW:  load_c = shifted;
      default: load_c = 32'h0;
    endcase
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      op_q    <= OPC_LB;
      lo_q    <= 2'b00;
      cnt     <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      RDATA   <= 32'h0;
      D_REQ   <= 1'b0;
      D_ADDR  <= 32'h0;
      D_WE    <= 1'b0;
      D_BE    <= 4'h0;
      D_WDATA <= 32'h0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ && req_any) begin
            op_q  <= req_op;
            lo_q  <= ADDR[1:0];
            BUSY  <= 1'b1;
            RDATA <= 32'h0;
            if (req_mis) begin
              state <= RESP;
              DONE  <= 1'b1;
              ERR   <= 1'b1;
            end else begin
              state   <= ACCESS;
              ERR     <= 1'b0;
              cnt     <= '0;
              D_REQ   <= 1'b1;
              D_WE    <= req_store;
              D_ADDR  <= {ADDR[31:2], 2'b00};
              D_BE    <= req_be;
              D_WDATA <= req_wd;
            end
          end
        end
        ACCESS: begin
          // An ack in the final wait cycle still wins over the timeout.
          if (D_ACK) begin
            state <= RESP;
            D_REQ <= 1'b0;
            D_WE  <= 1'b0;
            DONE  <= 1'b1;
            ERR   <= 1'b0;
            RDATA <= load_c;
          end else if (cnt == CNT_LAST) begin
            state <= RESP;
            D_REQ <= 1'b0;
            D_WE  <= 1'b0;
            DONE  <= 1'b1;
            ERR   <= 1'b1;
            RDATA <= 32'h0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          D_REQ <= 1'b0;
          D_WE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/core_lsu.md
# core_lsu

Load/store unit between the core's memory-access stage and the data memory port. It takes one load or store request per transaction and turns it into a word-aligned memory access with byte enables, lane-replicated store data and a req/ack handshake. Load data comes back lane-shifted and sign- or zero-extended. Misaligned accesses and memory timeouts are reported to the core as errors instead of being issued or waited on forever.

## Interface
- TIMEOUT, 255: maximum cycles D_REQ stays high without D_ACK before the access aborts. Range 1..255; the wait counter is 8 bits.
- CLK  in  1  clock
- RST_N  in  1  reset: synchronous, active-low; clock CLK
- REQ  in  1  request strobe from the core; sampled only in IDLE
- ADDR  in  32  byte address
- WDATA  in  32  store source (rs2); only the low byte or halfword is used for SB/SH
- OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW  in  1 each  operation select; exactly one is high with REQ
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  valid with DONE: 1 = misaligned or timeout
- RDATA  out  32  extended load result; valid from DONE until the next accept
- D_REQ  out  1  memory request; held until D_ACK or timeout
- D_ADDR  out  32  word address {ADDR[31:2], 2'b00}
- D_WE  out  1  store access
- D_BE  out  4  byte enables
- D_WDATA  out  32  lane-replicated store data
- D_ACK  in  1  memory acknowledge; completes the access in the cycle it is high with D_REQ
- D_RDATA  in  32  memory read word; valid with D_ACK

## Operation
- States: IDLE, ACCESS, RESP.
- **Accept:** REQ=1 in IDLE latches ADDR, WDATA and the op. REQ outside IDLE is ignored. REQ with zero op flags is ignored.
- **Alignment check, done at accept:**
  - LH/LHU/SH with ADDR[0]=1 is misaligned.
  - LW/SW with ADDR[1:0]≠0 is misaligned.
  - On misalignment, go to RESP with ERR=1. No memory access is made.
  - Otherwise go to ACCESS.
- **ACCESS:**
  - D_REQ=1. D_WE=1 for stores.
  - D_BE: byte ops 4'b0001<<ADDR[1:0]; half ops 4'b0011<<{ADDR[1],1'b0}; word ops 4'b1111.
  - D_WDATA: SB {4{WDATA[7:0]}}; SH {2{WDATA[15:0]}}; SW WDATA.
  - Memory-side outputs are driven from registers and are stable while D_REQ=1.
- **Completion:** D_ACK=1 in ACCESS captures D_RDATA, ERR=0, and moves to RESP.
- **Load extraction:** shift = D_RDATA >> (8*ADDR[1:0]). LB sign-extends bit 7, LBU zero-extends byte, LH sign-extends bit 15, LHU zero-extends half, LW takes the full word. Stores leave RDATA=0.
- **Timeout:** a counter clears on entry to ACCESS and increments each ACCESS cycle without D_ACK. When the count reaches TIMEOUT-1 without D_ACK, the next state is RESP with ERR=1, RDATA=0 and D_REQ dropped. If D_ACK arrives in that same cycle, the ack wins.
- **RESP:** DONE=1 for exactly one cycle, then IDLE. RDATA and ERR hold until the next accept.
- D_ACK outside ACCESS (late ack after timeout or reset) is ignored.

## Timing
- **Reset values:** state IDLE; BUSY, DONE, ERR, D_REQ, D_WE = 0; D_BE=0, D_ADDR=0, D_WDATA=0, RDATA=0; counter 0.
- **Reset mid-operation:** the next edge returns to IDLE with D_REQ=0. No DONE is issued for the aborted transaction.
- **Zero-wait access:** REQ at edge n; D_REQ high in cycle n+1; D_ACK in cycle n+1; DONE in cycle n+2. Request-to-DONE latency is 2 cycles.
- **k wait cycles:** DONE comes at n+2+k.
- **Misaligned:** DONE and ERR at cycle n+1. D_REQ never rises.
- **Timeout:** D_REQ is high for exactly TIMEOUT cycles; DONE follows in the next cycle.
- **Back-to-back:** a new REQ is accepted in the cycle after DONE (the first IDLE cycle). Minimum throughput is one transaction per 3 cycles.

## Test plan
- SW ADDR=0x100, WDATA=0xDEADBEEF, D_ACK same cycle -> D_ADDR=0x100, D_BE=1111, D_WE=1, D_WDATA=0xDEADBEEF; DONE 2 cycles after REQ, ERR=0.
- SB ADDR=0x103, WDATA=0x000000A5 -> D_BE=1000, D_WDATA=0xA5A5A5A5, D_ADDR=0x100. SH ADDR=0x102, WDATA=0x1234 -> D_BE=1100, D_WDATA=0x12341234.
- D_RDATA=0x80FF7F01:
  - LB @0x1 -> 0x0000007F
  - LB @0x3 -> 0xFFFFFF80
  - LBU @0x3 -> 0x00000080
  - LH @0x2 -> 0xFFFF80FF
  - LHU @0x0 -> 0x00007F01
  - LW @0x0 -> 0x80FF7F01
- LW ADDR=0x102 and LH ADDR=0x101 -> D_REQ stays 0; DONE and ERR=1 one cycle after REQ.
- TIMEOUT=4, no ack -> D_REQ high 4 cycles, then DONE with ERR=1, RDATA=0. A D_ACK pulse 2 cycles later is ignored, and a subsequent LW completes normally. Repeat with D_ACK on the 4th cycle -> ERR=0.
- Reset asserted in the 2nd ACCESS cycle of a 5-wait load -> D_REQ=0 and BUSY=0 after that edge, no DONE. REQ while BUSY=1 is ignored (no second access, D_ADDR unchanged).
